data_pipe_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one data_pipe_1ton write port among NUM independent DSIZE-wide valid/ready requesters.
- Grants one requester at a time and locks the grant for a whole packet, ending at in_last, or at a MAX_BURST-beat limit.
- Drives the pipe's wr_data, wr_vld and wr_align_last from the granted requester.
- Routes the pipe's wr_ready back to the granted requester only.
- Sits directly in front of data_pipe_1ton in the same clock domain.

---
 rtl/data_pipe_rr_arbiter_pkg.sv | 18 +
 rtl/data_pipe_rr_arbiter_if.sv | 37 +++
 rtl/data_pipe_rr_arbiter_pick.sv | 16 +
 rtl/data_pipe_rr_arbiter.sv | 90 +++++++++
 tb/tb_data_pipe_rr_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/data_pipe_rr_arbiter_pkg.sv
// data_pipe_arb_pkg: shared state type, width helper and round-robin pick function for the arbiter
package data_pipe_arb_pkg;
  localparam int MAX_NUM = 16;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  function automatic int idw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [3:0] rr_pick(input logic [MAX_NUM-1:0] req, input logic [3:0] last, input int num);
    logic [3:0] idx;
    logic [3:0] r;
    r = '0;
    for (int k = MAX_NUM; k >= 1; k--) begin
      idx = 4'((int'(last) + k) % num);
      if (k <= num && req[idx]) r = idx;
    end
    return r;
  endfunction
endpackage

// File: rtl/data_pipe_rr_arbiter_if.sv
// data_pipe_rr_arbiter_if: requester bundle, pipe write port and grant status of the arbiter
interface data_pipe_rr_arbiter_if #(
  parameter int DSIZE = 4,
  parameter int NUM   = 4,
  parameter int IDW   = data_pipe_arb_pkg::idw_f(NUM)
);
  logic [NUM*DSIZE-1:0] in_data;
  logic [NUM-1:0]       in_vld;
  logic [NUM-1:0]       in_last;
  logic [NUM-1:0]       in_ready;
  logic [DSIZE-1:0]     out_data;
  logic                 out_vld;
  logic                 out_align_last;
  logic                 out_ready;
  logic [IDW-1:0]       gnt_id;
  logic                 gnt_busy;
`ifdef DATA_PIPE_ARB_WATCHDOG_EN
  logic                 wd_release;
  modport slave (
    input  in_data, in_vld, in_last, out_ready,
    output in_ready, out_data, out_vld, out_align_last, gnt_id, gnt_busy, wd_release
  );
  modport master (
    output in_data, in_vld, in_last, out_ready,
    input  in_ready, out_data, out_vld, out_align_last, gnt_id, gnt_busy, wd_release
  );
`else
  modport slave (
    input  in_data, in_vld, in_last, out_ready,
    output in_ready, out_data, out_vld, out_align_last, gnt_id, gnt_busy
  );
  modport master (
    output in_data, in_vld, in_last, out_ready,
    input  in_ready, out_data, out_vld, out_align_last, gnt_id, gnt_busy
  );
`endif
endinterface

// File: rtl/data_pipe_rr_arbiter_pick.sv
// data_pipe_rr_pick: combinational rotate-priority encoder, the first request after last wins
module data_pipe_rr_pick import data_pipe_arb_pkg::*; #(
  parameter int NUM = 4,
  parameter int IDW = idw_f(NUM)
) (
  input  logic [NUM-1:0] req_i,
  input  logic [IDW-1:0] last_i,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);
  // Widen to the helper's fixed widths and narrow the winning index back
  always_comb begin
    idx_o = IDW'(rr_pick(MAX_NUM'(req_i), 4'(last_i), NUM));
    any_o = |req_i;
  end
endmodule

// File: rtl/data_pipe_rr_arbiter.sv
// data_pipe_rr_arbiter: round-robin front end sharing one data_pipe_1ton write port among NUM requesters.
// A grant is locked for a packet (in_last) or MAX_BURST beats. Defining DATA_PIPE_ARB_WATCHDOG_EN
// adds a stall watchdog that drops a grant idle for TIMEOUT cycles and pulses wd_release.
module data_pipe_rr_arbiter import data_pipe_arb_pkg::*; #(
  parameter int DSIZE     = 4,
  parameter int NUM       = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 8
) (
  input logic                   clock,
  input logic                   rst_n,
  data_pipe_rr_arbiter_if.slave bus
);
  localparam int IDW = idw_f(NUM);
  arb_state_t     state_q;
  logic [IDW-1:0] gnt_q;
  logic [IDW-1:0] last_gnt_q;
  logic [IDW-1:0] pick_idx;
  logic [7:0]     beat_cnt_q;
  logic [7:0]     beat_cnt_d;
  logic           pick_any;
  logic           locked;
  logic           vld_g;
  logic           accept;
  logic           align_last;
  logic           rel;
  logic           wd_fire;
  data_pipe_rr_pick #(.NUM(NUM), .IDW(IDW)) u_pick (
    .req_i  (bus.in_vld),
    .last_i (last_gnt_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );
  // Datapath mux, ready routing and release decision follow the locked grant combinationally
  always_comb begin
    locked             = state_q == LOCKED;
    vld_g              = locked & bus.in_vld[gnt_q];
    accept             = vld_g & bus.out_ready;
    align_last         = vld_g & (bus.in_last[gnt_q] | (beat_cnt_q == 8'(MAX_BURST - 1)));
    rel                = (accept & align_last) | wd_fire;
    beat_cnt_d         = rel ? 8'd0 : accept ? beat_cnt_q + 8'd1 : beat_cnt_q;
    bus.out_data       = locked ? bus.in_data[gnt_q*DSIZE +: DSIZE] : '0;
    bus.out_vld        = vld_g;
    bus.out_align_last = align_last;
    bus.in_ready       = locked ? NUM'(bus.out_ready) << gnt_q : '0;
    bus.gnt_id         = gnt_q;
    bus.gnt_busy       = locked;
  end
  // Grant FSM: arbitrate in IDLE (one bubble), hold the grant in LOCKED until release
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= IDW'(NUM - 1);
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else if (!locked) begin
      if (pick_any) begin
        state_q <= LOCKED;
        gnt_q   <= pick_idx;
      end
    end else begin
      beat_cnt_q <= beat_cnt_d;
      if (rel) begin
        state_q    <= IDLE;
        last_gnt_q <= gnt_q;
      end
    end
  end
`ifdef DATA_PIPE_ARB_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q;
  logic [SW-1:0] stall_d;
  logic          wd_release_q;
  assign wd_fire = locked & ~bus.in_vld[gnt_q] & (stall_q == SW'(TIMEOUT - 1));
  assign stall_d = (!locked || bus.in_vld[gnt_q] || wd_fire) ? '0 : stall_q + 1'b1;
  assign bus.wd_release = wd_release_q;
  // Count consecutive idle cycles of the granted requester and pulse on forced release
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stall_q      <= '0;
      wd_release_q <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      wd_release_q <= wd_fire;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif
endmodule

// File: tb/tb_data_pipe_rr_arbiter.sv
// tb_data_pipe_rr_arbiter: directed checks of reset, rotation, burst limit, backpressure and mid-packet reset
module tb_data_pipe_rr_arbiter;
  logic clock = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rem[4];
  int seq[4];
  int plen[4];
  int pcnt[4];
  logic [3:0] hs;
  bit bp = 1'b0;
  int lg[$];
  int lc[$];
  int rot_exp[15] = '{'h000, 'h002, 'h005, 'h106, 'h108, 'h10b, 'h20c, 'h20e, 'h211,
                      'h312, 'h314, 'h317, 'h006, 'h008, 'h00b};
  data_pipe_rr_arbiter_if #(.DSIZE(4), .NUM(4)) bus ();
  data_pipe_rr_arbiter #(.DSIZE(4), .NUM(4), .MAX_BURST(16), .TIMEOUT(8)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.in_vld[i]         = rem[i] != 0;
      bus.in_data[i*4 +: 4] = 4'(seq[i]);
      bus.in_last[i]        = rem[i] != 0 && plen[i] != 0 && pcnt[i] == plen[i] - 1;
    end
  endtask

  task automatic req(input int i, input int n, input int pl, input int s0);
    rem[i]  = n;
    plen[i] = pl;
    seq[i]  = s0;
    pcnt[i] = 0;
    drive();
  endtask

  task automatic zero_chk(input string tag);
    chk(tag, 32'({bus.in_ready, bus.out_vld, bus.out_align_last, bus.gnt_busy, bus.out_data}), 32'd0);
    chk({tag, "_gnt"}, 32'(bus.gnt_id), 32'd0);
  endtask

  task automatic cycle();
    logic [3:0] er;
    @(negedge clock);
    cyc++;
    er = bus.gnt_busy ? (4'(bus.out_ready) << bus.gnt_id) : 4'b0;
    chk("rdy_route", 32'(bus.in_ready), 32'(er));
    if (bus.out_vld && bus.out_ready) begin
      lg.push_back((int'(bus.gnt_id) << 8) | (int'(bus.out_data) << 1) | int'(bus.out_align_last));
      lc.push_back(cyc);
    end
    hs = bus.in_vld & bus.in_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i]) begin
        rem[i]--;
        seq[i]++;
        pcnt[i] = (plen[i] != 0 && pcnt[i] == plen[i] - 1) ? 0 : pcnt[i] + 1;
      end
    if (bp) bus.out_ready = ~bus.out_ready;
    drive();
    #1;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int k = 0; k < budget && lg.size() < n; k++) cycle();
    chk("beats", 32'(lg.size()), 32'(n));
  endtask

  task automatic rst_pulse();
    @(posedge clock);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    rst_n = 1'b1;
    lg.delete();
    lc.delete();
  endtask

  initial begin
    int nl;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) req(i, i == 0 ? 6 : 3, 3, i * 3);
    repeat (5) @(posedge clock);
    #2;
    zero_chk("rst");
    rst_n = 1'b1;
    #1;
    chk("idle_busy", 32'(bus.gnt_busy), 32'd0);
    chk("idle_vld", 32'(bus.out_vld), 32'd0);
    cycle();
    chk("first_gnt", 32'(bus.gnt_id), 32'd0);
    chk("first_busy", 32'(bus.gnt_busy), 32'd1);
    chk("first_rdy", 32'(bus.in_ready), 32'h1);
    chk("first_data", 32'(bus.out_data), 32'd0);
    run_until(15, 100);
    if (lg.size() == 15)
      for (int j = 0; j < 15; j++) begin
        chk("rot_beat", 32'(lg[j]), 32'(rot_exp[j]));
        chk("rot_time", 32'(lc[j] - lc[0]), 32'((j / 3) * 4 + j % 3));
      end
    cycle();
    cycle();
    chk("rot_idle", 32'(bus.gnt_busy), 32'd0);
    chk("rot_idle_vld", 32'(bus.out_vld), 32'd0);

    lg.delete();
    lc.delete();
    req(2, 40, 0, 0);
    run_until(40, 200);
    if (lg.size() == 40)
      for (int j = 0; j < 40; j++) begin
        chk("burst_beat", 32'(lg[j]), 32'('h200 | ((j % 16) << 1) | ((j == 15 || j == 31) ? 1 : 0)));
        chk("burst_time", 32'(lc[j] - lc[0]), 32'(j + j / 16));
      end
    repeat (3) cycle();
    chk("lock_hold_busy", 32'(bus.gnt_busy), 32'd1);
    chk("lock_hold_gnt", 32'(bus.gnt_id), 32'd2);
    chk("lock_hold_beats", 32'(lg.size()), 32'd40);
    rst_pulse();

    bp = 1'b1;
    bus.out_ready = 1'b1;
    req(1, 8, 8, 0);
    run_until(8, 100);
    if (lg.size() == 8)
      for (int j = 0; j < 8; j++) begin
        chk("bp_beat", 32'(lg[j]), 32'('h100 | (j << 1) | (j == 7 ? 1 : 0)));
        chk("bp_time", 32'(lc[j] - lc[0]), 32'(2 * j));
      end
    repeat (4) cycle();
    chk("bp_nodup", 32'(lg.size()), 32'd8);
    chk("bp_idle", 32'(bus.gnt_busy), 32'd0);
    bp = 1'b0;
    bus.out_ready = 1'b1;

    lg.delete();
    lc.delete();
    req(0, 16, 16, 0);
    run_until(16, 100);
    nl = 0;
    foreach (lg[j]) nl += lg[j] & 1;
    chk("coinc_lasts", 32'(nl), 32'd1);
    if (lg.size() == 16) chk("coinc_end", 32'(lg[15]), 32'h01f);
    cycle();
    cycle();
    chk("coinc_idle", 32'(bus.gnt_busy), 32'd0);

    lg.delete();
    lc.delete();
    req(3, 8, 8, 0);
    run_until(5, 50);
    chk("mid_gnt3", 32'(bus.gnt_id), 32'd3);
    rst_n = 1'b0;
    req(0, 1, 1, 9);
    #1;
    zero_chk("mid_rst");
    repeat (2) @(posedge clock);
    #2;
    zero_chk("mid_rst_hold");
    rst_n = 1'b1;
    lg.delete();
    lc.delete();
    cycle();
    chk("post_gnt", 32'(bus.gnt_id), 32'd0);
    chk("post_data", 32'(bus.out_data), 32'd9);
    chk("post_last", 32'(bus.out_align_last), 32'd1);
    chk("post_rdy", 32'(bus.in_ready), 32'h1);
    run_until(4, 40);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
